// File: rtl/asym_fifo_pkg.sv
// Shared types and slice-count helpers for the asymmetric-width FIFO.
package asym_fifo_pkg;

  typedef enum logic {
    WIDE_TO_NARROW = 1'b0,
    NARROW_TO_WIDE = 1'b1
  } fifo_mode_e;

  function automatic fifo_mode_e mode_from_int(int mode);
    return (mode == 1) ? NARROW_TO_WIDE : WIDE_TO_NARROW;
  endfunction

  function automatic int slices_per_write(fifo_mode_e mode, int ratio);
    return (mode == WIDE_TO_NARROW) ? ratio : 1;
  endfunction

  function automatic int slices_per_read(fifo_mode_e mode, int ratio);
    return (mode == NARROW_TO_WIDE) ? ratio : 1;
  endfunction

endpackage

// File: rtl/asym_fifo_ctrl.sv
// Pointer/occupancy controller for asym_fifo_gen: accept logic, full/empty, and
// the sticky overflow/underflow flags when built with ASYM_FIFO_ERR_EN.
module asym_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int WS         = 2,
  parameter int RS         = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_acc,
  output logic                  rd_acc,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr
`ifdef ASYM_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] WS_L    = (ADDR_WIDTH+1)'(WS);
  localparam logic [ADDR_WIDTH:0] RS_L    = (ADDR_WIDTH+1)'(RS);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count;

  // The extra pointer MSB lets count reach the full depth without ambiguity.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (DEPTH_L - count) < WS_L;
  assign empty   = count < RS_L;
  assign wr_acc  = wr & ~full;
  assign rd_acc  = rd & ~empty;
  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + WS_L;
      if (rd_acc) rd_ptr <= rd_ptr + RS_L;
    end
  end

`ifdef ASYM_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/asym_fifo_gen.sv
// Asymmetric-width first-word-fall-through FIFO (wide->narrow or narrow->wide).
// Define ASYM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module asym_fifo_gen
  import asym_fifo_pkg::*;
#(
  parameter  int NARROW_WIDTH = 4,
  parameter  int RATIO        = 2,
  parameter  int ADDR_WIDTH   = 3,
  parameter  int MODE         = 0,
  localparam int W_W = slices_per_write(mode_from_int(MODE), RATIO) * NARROW_WIDTH,
  localparam int R_W = slices_per_read(mode_from_int(MODE), RATIO) * NARROW_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr,
  input  logic           rd,
  input  logic [W_W-1:0] w_data,
  output logic [R_W-1:0] r_data,
  output logic           full,
  output logic           empty
`ifdef ASYM_FIFO_ERR_EN
  ,
  output logic           overflow,
  output logic           underflow
`endif
);

  localparam fifo_mode_e MODE_E = mode_from_int(MODE);
  localparam int         WS     = slices_per_write(MODE_E, RATIO);
  localparam int         RS     = slices_per_read(MODE_E, RATIO);
  localparam int         DEPTH  = 2**ADDR_WIDTH;

  logic                    wr_acc;
  logic                    rd_acc;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [NARROW_WIDTH-1:0] mem [DEPTH];

  asym_fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WS         (WS),
    .RS         (RS)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .rd        (rd),
    .wr_acc    (wr_acc),
    .rd_acc    (rd_acc),
    .full      (full),
    .empty     (empty),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr)
`ifdef ASYM_FIFO_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  // NOTE: storage is cleared on reset so r_data is never X, even while empty;
  // this costs a reset on every slice register instead of a plain RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc) begin
      // Least-significant slice goes to the lowest address, so it leaves first.
      for (int i = 0; i < WS; i++)
        mem[wr_addr + ADDR_WIDTH'(i)] <= w_data[i*NARROW_WIDTH +: NARROW_WIDTH];
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    r_data = '0;
    for (int i = 0; i < RS; i++)
      r_data[i*NARROW_WIDTH +: NARROW_WIDTH] = mem[rd_addr + ADDR_WIDTH'(i)];
  end

endmodule

// File: tb/tb_asym_fifo_gen.sv
// Directed self-checking bench: one wide->narrow and one narrow->wide instance
// (NARROW_WIDTH=4, RATIO=2, ADDR_WIDTH=3) sharing clock and reset.
module tb_asym_fifo_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr0, rd0, wr1, rd1;
  logic [7:0] wd0;
  logic [3:0] rdat0;
  logic [3:0] wd1;
  logic [7:0] rdat1;
  logic       full0, empty0, full1, empty1;
`ifdef ASYM_FIFO_ERR_EN
  logic       ovf0, unf0, ovf1, unf1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  asym_fifo_gen #(.NARROW_WIDTH(4), .RATIO(2), .ADDR_WIDTH(3), .MODE(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr0),
    .rd        (rd0),
    .w_data    (wd0),
    .r_data    (rdat0),
    .full      (full0),
    .empty     (empty0)
`ifdef ASYM_FIFO_ERR_EN
    ,
    .overflow  (ovf0),
    .underflow (unf0)
`endif
  );

  asym_fifo_gen #(.NARROW_WIDTH(4), .RATIO(2), .ADDR_WIDTH(3), .MODE(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr1),
    .rd        (rd1),
    .w_data    (wd1),
    .r_data    (rdat1),
    .full      (full1),
    .empty     (empty1)
`ifdef ASYM_FIFO_ERR_EN
    ,
    .overflow  (ovf1),
    .underflow (unf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] words [9] = '{8'hA5, 8'hD2, 8'h3C, 8'h71, 8'hE8, 8'h4B, 8'h1F, 8'hC6, 8'h59};
  logic [3:0] drain [6] = '{4'h6, 4'h9, 4'h5, 4'hA, 4'h2, 4'hD};

  initial begin
    logic [7:0] prev;
    reset = 1'b0;
    wr0 = 0; rd0 = 0; wd0 = '0;
    wr1 = 0; rd1 = 0; wd1 = '0;

    // 1. reset state, then idle after release
    tick(); tick();
    check("rst_empty0", 32'(empty0), 32'd1);
    check("rst_full0",  32'(full0),  32'd0);
    check("rst_rdata0", 32'(rdat0),  32'h0);
    check("rst_empty1", 32'(empty1), 32'd1);
    check("rst_rdata1", 32'(rdat1),  32'h0);
    reset = 1'b1;
    tick(); tick();
    check("idle_empty0", 32'(empty0), 32'd1);
    check("idle_full0",  32'(full0),  32'd0);

    // 2. single wide word splits LSB slice first
    wr0 = 1; wd0 = 8'hF0;
    tick();
    wr0 = 0;
    check("w1_empty0", 32'(empty0), 32'd0);
    check("w1_head0",  32'(rdat0),  32'h0);
    rd0 = 1;
    tick();
    check("w1_head1", 32'(rdat0), 32'hF);
    check("w1_nempty", 32'(empty0), 32'd0);
    tick();
    rd0 = 0;
    check("w1_drained", 32'(empty0), 32'd1);

    // 3. fill to full, refused 5th write, release by single reads
    wr0 = 1;
    wd0 = 8'hF0; tick();
    wd0 = 8'h96; tick();
    wd0 = 8'hA5; tick();
    wd0 = 8'hD2; tick();
    check("fill_full", 32'(full0), 32'd1);
    wd0 = 8'h0F; tick();
    wr0 = 0;
    check("ovf_full",  32'(full0), 32'd1);
    check("ovf_head",  32'(rdat0), 32'h0);
`ifdef ASYM_FIFO_ERR_EN
    check("ovf_flag",  32'(ovf0), 32'd1);
    check("unf_clear", 32'(unf0), 32'd0);
`endif
    rd0 = 1;
    tick();
    check("cnt7_full", 32'(full0), 32'd1);
    check("cnt7_head", 32'(rdat0), 32'hF);
    tick();
    check("cnt6_full", 32'(full0), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("drain%0d", i), 32'(rdat0), 32'(drain[i]));
      tick();
    end
    rd0 = 0;
    check("drain_empty", 32'(empty0), 32'd1);

    // 4. wr+rd on empty: read refused; then lagging wr+rd / rd pattern across wrap
    wr0 = 1; rd0 = 1; wd0 = 8'h96;
    tick();
    check("wr_rd_empty", 32'(empty0), 32'd0);
    check("wr_rd_head",  32'(rdat0),  32'h6);
`ifdef ASYM_FIFO_ERR_EN
    check("unf_flag", 32'(unf0), 32'd1);
`endif
    prev = 8'h96;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("pat%0d_lo", k), 32'(rdat0), 32'(prev[3:0]));
      wr0 = 1; rd0 = 1; wd0 = words[k];
      tick();
      check($sformatf("pat%0d_hi", k), 32'(rdat0), 32'(prev[7:4]));
      wr0 = 0; rd0 = 1;
      tick();
      prev = words[k];
    end
    check("pat_last_lo", 32'(rdat0), 32'h9);
    tick();
    check("pat_last_hi", 32'(rdat0), 32'h5);
    tick();
    rd0 = 0;
    check("pat_empty", 32'(empty0), 32'd1);

    // 5. narrow->wide: partial word stays hidden, fill and release
    wr1 = 1; wd1 = 4'h3;
    tick();
    check("m1_partial", 32'(empty1), 32'd1);
    wd1 = 4'hC;
    tick();
    check("m1_empty", 32'(empty1), 32'd0);
    check("m1_word",  32'(rdat1),  32'hC3);
    for (int i = 1; i <= 5; i++) begin
      wd1 = 4'(i);
      tick();
    end
    check("m1_cnt7_full", 32'(full1), 32'd0);
    wd1 = 4'h6;
    tick();
    check("m1_full", 32'(full1), 32'd1);
    wd1 = 4'h7;
    tick();
    wr1 = 0;
    check("m1_still_full", 32'(full1), 32'd1);
`ifdef ASYM_FIFO_ERR_EN
    check("m1_ovf", 32'(ovf1), 32'd1);
`endif
    rd1 = 1;
    tick();
    rd1 = 0;
    check("m1_rd_full", 32'(full1), 32'd0);
    check("m1_rd_word", 32'(rdat1), 32'h21);

    // 6. reset with traffic on a half-full FIFO
    wr0 = 1;
    wd0 = 8'hF0; tick();
    wd0 = 8'h96; tick();
    reset = 0; wd0 = 8'hA5; rd0 = 1; wr1 = 1; rd1 = 1; wd1 = 4'h9;
    tick();
    reset = 1; wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    check("mrst_empty0", 32'(empty0), 32'd1);
    check("mrst_full0",  32'(full0),  32'd0);
    check("mrst_rdata0", 32'(rdat0),  32'h0);
    check("mrst_empty1", 32'(empty1), 32'd1);
    check("mrst_rdata1", 32'(rdat1),  32'h0);
`ifdef ASYM_FIFO_ERR_EN
    check("mrst_ovf0", 32'(ovf0), 32'd0);
    check("mrst_unf0", 32'(unf0), 32'd0);
    check("mrst_ovf1", 32'(ovf1), 32'd0);
`endif
    wr0 = 1; wd0 = 8'h3C;
    tick();
    wr0 = 0;
    check("post_rst_head", 32'(rdat0), 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
